// File: rtl/imx_lane_tap_calibrator.sv
// Per-camera IDELAY tap calibrator: sweeps taps 0..31 on each LVDS lane, scores each tap against a training word, then loads the centre of the widest passing eye.
// Optional per-lane eye bitmap readback when IMX_TAP_CAL_EYE_MAP_EN is defined.
module imx_lane_tap_calibrator #(
  parameter int unsigned LANE_WIDTH    = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned WINDOW        = 64,
  parameter int unsigned MIN_EYE       = 4,
  parameter int unsigned DEFAULT_TAP   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [7:0]              i_train_word,
  input  logic [8*LANE_WIDTH-1:0] i_lane_data,
  output logic [5*LANE_WIDTH-1:0] o_tap_data,
  output logic [LANE_WIDTH-1:0]   o_tap_load,
  output logic                    o_tap_delay_rst,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [LANE_WIDTH-1:0]   o_lane_fail,
  input  logic [2:0]              i_map_sel,
  output logic [31:0]             o_eye_map
);

  localparam int unsigned LANE_IDX_W = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
  localparam int unsigned SETTLE_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned WIN_W      = $clog2(WINDOW + 1);
  localparam int unsigned TAP_W      = 5;
  localparam int unsigned LEN_W      = 6;
  localparam logic [TAP_W-1:0] DEF_TAP = TAP_W'(DEFAULT_TAP);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_TAPS, S_SET_TAP, S_SETTLE, S_SAMPLE, S_EVAL, S_APPLY, S_NEXT_LANE, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              train_q, train_d;
  logic [LANE_IDX_W-1:0]   lane_q, lane_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic [SETTLE_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [WIN_W-1:0]        sample_cnt_q, sample_cnt_d;
  logic [WIN_W-1:0]        match_q, match_d;
  logic                    in_run_q, in_run_d;
  logic [TAP_W-1:0]        run_start_q, run_start_d;
  logic [LEN_W-1:0]        run_len_q, run_len_d;
  logic [TAP_W-1:0]        best_start_q, best_start_d;
  logic [LEN_W-1:0]        best_len_q, best_len_d;
  logic [5*LANE_WIDTH-1:0] tap_data_q, tap_data_d;
  logic [LANE_WIDTH-1:0]   tap_load_q, tap_load_d;
  logic                    tap_delay_rst_q, tap_delay_rst_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [LANE_WIDTH-1:0]   lane_fail_q, lane_fail_d;

  logic                    start_ok_c;
  logic                    pass_c;
  logic [LEN_W-1:0]        cur_len_c;
  logic [TAP_W-1:0]        cur_start_c;
  logic [LEN_W-1:0]        half_len_c;
  logic [TAP_W-1:0]        final_tap_c;
  logic [7:0]              lane_byte_c;

  assign start_ok_c  = (state_q == S_IDLE) && i_start && !i_abort;
  assign pass_c      = (match_q == WIN_W'(WINDOW));
  assign cur_len_c   = in_run_q ? (run_len_q + LEN_W'(1)) : LEN_W'(1);
  assign cur_start_c = in_run_q ? run_start_q : tap_q;
  assign half_len_c  = (best_len_q - LEN_W'(1)) >> 1;
  assign final_tap_c = TAP_W'({1'b0, best_start_q} + half_len_c);
  assign lane_byte_c = i_lane_data[8*lane_q +: 8];

  // Next-state and datapath updates; abort overrides everything outside IDLE.
  always_comb begin
    state_d         = state_q;
    train_d         = train_q;
    lane_d          = lane_q;
    tap_d           = tap_q;
    settle_cnt_d    = settle_cnt_q;
    sample_cnt_d    = sample_cnt_q;
    match_d         = match_q;
    in_run_d        = in_run_q;
    run_start_d     = run_start_q;
    run_len_d       = run_len_q;
    best_start_d    = best_start_q;
    best_len_d      = best_len_q;
    tap_data_d      = tap_data_q;
    tap_load_d      = '0;
    tap_delay_rst_d = 1'b0;
    busy_d          = busy_q;
    done_d          = done_q;
    lane_fail_d     = lane_fail_q;

    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok_c) begin
            train_d      = i_train_word;
            lane_d       = '0;
            tap_d        = '0;
            settle_cnt_d = '0;
            sample_cnt_d = '0;
            match_d      = '0;
            in_run_d     = 1'b0;
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
            done_d       = 1'b0;
            lane_fail_d  = '0;
            busy_d       = 1'b1;
            state_d      = S_RST_TAPS;
          end
        end
        S_RST_TAPS: begin
          tap_delay_rst_d = 1'b1;
          tap_d           = '0;
          state_d         = S_SET_TAP;
        end
        S_SET_TAP: begin
          tap_data_d[5*lane_q +: 5] = tap_q;
          tap_load_d[lane_q]        = 1'b1;
          settle_cnt_d              = '0;
          state_d                   = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            settle_cnt_d = '0;
            sample_cnt_d = '0;
            state_d      = S_SAMPLE;
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
          end
        end
        S_SAMPLE: begin
          if ((lane_byte_c == train_q) && (match_q != WIN_W'(WINDOW))) begin
            match_d = match_q + WIN_W'(1);
          end
          if (sample_cnt_q == WIN_W'(WINDOW - 1)) begin
            sample_cnt_d = '0;
            state_d      = S_EVAL;
          end else begin
            sample_cnt_d = sample_cnt_q + WIN_W'(1);
          end
        end
        S_EVAL: begin
          // A run closes on the first failing tap or at the end of the sweep; ties keep the earlier run.
          if (pass_c) begin
            in_run_d    = 1'b1;
            run_len_d   = cur_len_c;
            run_start_d = cur_start_c;
            if ((tap_q == TAP_W'(31)) && (cur_len_c > best_len_q)) begin
              best_len_d   = cur_len_c;
              best_start_d = cur_start_c;
            end
          end else begin
            in_run_d  = 1'b0;
            run_len_d = '0;
            if (in_run_q && (run_len_q > best_len_q)) begin
              best_len_d   = run_len_q;
              best_start_d = run_start_q;
            end
          end
          match_d = '0;
          if (tap_q != TAP_W'(31)) begin
            tap_d   = tap_q + TAP_W'(1);
            state_d = S_SET_TAP;
          end else begin
            state_d = S_APPLY;
          end
        end
        S_APPLY: begin
          if (best_len_q >= LEN_W'(MIN_EYE)) begin
            tap_data_d[5*lane_q +: 5] = final_tap_c;
          end else begin
            tap_data_d[5*lane_q +: 5] = DEF_TAP;
            lane_fail_d[lane_q]       = 1'b1;
          end
          tap_load_d[lane_q] = 1'b1;
          state_d            = S_NEXT_LANE;
        end
        S_NEXT_LANE: begin
          in_run_d     = 1'b0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          tap_d        = '0;
          if (lane_q == LANE_IDX_W'(LANE_WIDTH - 1)) begin
            state_d = S_DONE;
          end else begin
            lane_d  = lane_q + LANE_IDX_W'(1);
            state_d = S_SET_TAP;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      train_q         <= '0;
      lane_q          <= '0;
      tap_q           <= '0;
      settle_cnt_q    <= '0;
      sample_cnt_q    <= '0;
      match_q         <= '0;
      in_run_q        <= 1'b0;
      run_start_q     <= '0;
      run_len_q       <= '0;
      best_start_q    <= '0;
      best_len_q      <= '0;
      tap_data_q      <= {LANE_WIDTH{DEF_TAP}};
      tap_load_q      <= '0;
      tap_delay_rst_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      lane_fail_q     <= '0;
    end else begin
      state_q         <= state_d;
      train_q         <= train_d;
      lane_q          <= lane_d;
      tap_q           <= tap_d;
      settle_cnt_q    <= settle_cnt_d;
      sample_cnt_q    <= sample_cnt_d;
      match_q         <= match_d;
      in_run_q        <= in_run_d;
      run_start_q     <= run_start_d;
      run_len_q       <= run_len_d;
      best_start_q    <= best_start_d;
      best_len_q      <= best_len_d;
      tap_data_q      <= tap_data_d;
      tap_load_q      <= tap_load_d;
      tap_delay_rst_q <= tap_delay_rst_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      lane_fail_q     <= lane_fail_d;
    end
  end

  assign o_tap_data      = tap_data_q;
  assign o_tap_load      = tap_load_q;
  assign o_tap_delay_rst = tap_delay_rst_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_lane_fail     = lane_fail_q;

`ifdef IMX_TAP_CAL_EYE_MAP_EN
  // Lane n's bitmap lives at bits [32n+31:32n]; {lane, tap} addresses one pass bit.
  logic [32*LANE_WIDTH-1:0] eye_q, eye_d;
  logic [31:0]              eye_sel_c;
  logic [31:0]              eye_map_q;

  always_comb begin
    eye_d = eye_q;
    if (start_ok_c) begin
      eye_d = '0;
    end else if ((state_q == S_EVAL) && !i_abort) begin
      eye_d[{lane_q, tap_q}] = pass_c;
    end
  end

  always_comb begin
    eye_sel_c = '0;
    for (int l = 0; l < int'(LANE_WIDTH); l++) begin
      if (int'(i_map_sel) == l) eye_sel_c = eye_q[32*l +: 32];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      eye_q     <= '0;
      eye_map_q <= '0;
    end else begin
      eye_q     <= eye_d;
      eye_map_q <= eye_sel_c;
    end
  end

  assign o_eye_map = eye_map_q;
`else
  logic unused_map_sel;
  assign unused_map_sel = ^i_map_sel;
  assign o_eye_map      = '0;
`endif

endmodule

// File: tb/tb_imx_lane_tap_calibrator.sv
// Directed bench for imx_lane_tap_calibrator: a lane model returns the training word only at taps inside each lane's eye mask.
module tb_imx_lane_tap_calibrator;

  localparam int LW       = 8;
  localparam int SETTLE   = 2;
  localparam int WIN      = 4;
  // 2 cycles for RST_TAPS and DONE, plus 32*(1+SETTLE+WIN+1)+2 per lane.
  localparam int BUSY_CYC = 2066;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic              i_abort;
  logic [7:0]        i_train_word;
  logic [8*LW-1:0]   i_lane_data;
  logic [5*LW-1:0]   o_tap_data;
  logic [LW-1:0]     o_tap_load;
  logic              o_tap_delay_rst;
  logic              o_busy;
  logic              o_done;
  logic [LW-1:0]     o_lane_fail;
  logic [2:0]        i_map_sel;
  logic [31:0]       o_eye_map;

  logic [31:0] eye_mask [LW] = '{default: 32'h0};
  int rst_cnt = 0;
  int busy_cnt = 0;
  int load_cnt [LW] = '{default: 0};
  int n_checks = 0;
  int n_pass = 0;

  imx_lane_tap_calibrator #(
    .LANE_WIDTH(LW), .SETTLE_CYCLES(SETTLE), .WINDOW(WIN), .MIN_EYE(4), .DEFAULT_TAP(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_train_word(i_train_word), .i_lane_data(i_lane_data),
    .o_tap_data(o_tap_data), .o_tap_load(o_tap_load), .o_tap_delay_rst(o_tap_delay_rst),
    .o_busy(o_busy), .o_done(o_done), .o_lane_fail(o_lane_fail),
    .i_map_sel(i_map_sel), .o_eye_map(o_eye_map)
  );

  always #5 clk = ~clk;

  // Lane model: correct byte only while the lane's current tap lies in its eye.
  always_comb begin
    for (int l = 0; l < LW; l++) begin
      i_lane_data[8*l +: 8] = eye_mask[l][o_tap_data[5*l +: 5]] ? i_train_word : ~i_train_word;
    end
  end

  always @(negedge clk) begin
    if (o_tap_delay_rst) rst_cnt++;
    if (o_busy) busy_cnt++;
    for (int l = 0; l < LW; l++) if (o_tap_load[l]) load_cnt[l]++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [5*LW-1:0] taps(input int t0, input int t1, input int t2, input int tr);
    logic [5*LW-1:0] v;
    for (int l = 0; l < LW; l++) v[5*l +: 5] = 5'(tr);
    v[4:0]   = 5'(t0);
    v[9:5]   = 5'(t1);
    v[14:10] = 5'(t2);
    return v;
  endfunction

  task automatic set_masks(input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] m2,
                           input logic [31:0] mr);
    for (int l = 0; l < LW; l++) eye_mask[l] = mr;
    eye_mask[0] = m0;
    eye_mask[1] = m1;
    eye_mask[2] = m2;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!o_done && k < 6000) begin @(negedge clk); k++; end
    check(tag, 64'(o_done), 64'd1);
  endtask

  task automatic wait_load(input int lane, input int base, input string tag);
    int k = 0;
    while (load_cnt[lane] <= base && k < 6000) begin @(negedge clk); #1; k++; end
    check(tag, 64'(load_cnt[lane] > base), 64'd1);
  endtask

  task automatic check_map(input logic [2:0] sel, input logic [31:0] mask, input string tag);
    logic [31:0] exp;
`ifdef IMX_TAP_CAL_EYE_MAP_EN
    exp = mask;
`else
    exp = 32'h0;
`endif
    i_map_sel = sel;
    @(posedge clk); @(posedge clk); #1;
    check(tag, 64'(o_eye_map), 64'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tap"}, 64'(o_tap_data), 64'(taps(16, 16, 16, 16)));
    check({tag, "_load"}, 64'(o_tap_load), 64'd0);
    check({tag, "_drst"}, 64'(o_tap_delay_rst), 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_done"}, 64'(o_done), 64'd0);
    check({tag, "_fail"}, 64'(o_lane_fail), 64'd0);
  endtask

  initial begin
    int rst0, busy0, b1, b3;
    int ld0 [LW];
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_train_word = 8'hA5; i_map_sel = 3'd0;
    #12;
    check_reset_outputs("reset");
    check("reset_map", 64'(o_eye_map), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic eyes: lane0 10..20, others 4..9.
    set_masks(32'h001F_FC00, 32'h0000_03F0, 32'h0000_03F0, 32'h0000_03F0);
    rst0 = rst_cnt; busy0 = busy_cnt;
    for (int l = 0; l < LW; l++) ld0[l] = load_cnt[l];
    pulse_start();
    wait_done("t1_done");
    #1;
    check("t1_taps", 64'(o_tap_data), 64'(taps(15, 6, 6, 6)));
    check("t1_fail", 64'(o_lane_fail), 64'd0);
    check("t1_busy", 64'(o_busy), 64'd0);
    check("t1_drst_cnt", 64'(rst_cnt - rst0), 64'd1);
    check("t1_busy_cycles", 64'(busy_cnt - busy0), 64'(BUSY_CYC));
    for (int l = 0; l < LW; l++) check($sformatf("t1_loads_lane%0d", l), 64'(load_cnt[l] - ld0[l]), 64'd33);
    check_map(3'd0, 32'h001F_FC00, "t1_map0");

    // Tie, eye at sweep end, narrow eye.
    set_masks(32'h01F0_00F8, 32'hFE00_0000, 32'h0000_3000, 32'h0000_03F0);
    pulse_start();
    check("t2_done_cleared", 64'(o_done), 64'd0);
    wait_done("t2_done");
    #1;
    check("t2_taps", 64'(o_tap_data), 64'(taps(5, 28, 16, 6)));
    check("t2_fail", 64'(o_lane_fail), 64'h04);
    check_map(3'd1, 32'hFE00_0000, "t2_map1");
    check_map(3'd2, 32'h0000_3000, "t2_map2");

    // Start while busy is ignored; abort during lane 3 SAMPLE.
    set_masks(32'h001F_FC00, 32'h0000_03F0, 32'h0000_03F0, 32'h0000_03F0);
    rst0 = rst_cnt;
    for (int l = 0; l < LW; l++) ld0[l] = load_cnt[l];
    pulse_start();
    wait_load(1, ld0[1], "t3_lane1_seen");
    pulse_start();
    wait_load(3, ld0[3], "t3_lane3_seen");
    @(posedge clk); @(posedge clk); #1 i_abort = 1'b1;
    @(posedge clk); #1 i_abort = 1'b0;
    check("t3_abort_busy", 64'(o_busy), 64'd0);
    check("t3_abort_done", 64'(o_done), 64'd0);
    check("t3_drst_cnt", 64'(rst_cnt - rst0), 64'd1);
    check("t3_lane0_loads", 64'(load_cnt[0] - ld0[0]), 64'd33);
    check("t3_taps_kept", 64'(o_tap_data[19:0]), 64'(taps(15, 6, 6, 0) & 40'hF_FFFF));
    b1 = load_cnt[3];
    b3 = busy_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("t3_idle_no_load", 64'(load_cnt[3] - b1), 64'd0);
    check("t3_idle_no_busy", 64'(busy_cnt - b3), 64'd0);

    // Asynchronous reset in the middle of SETTLE, then a clean run.
    rst0 = load_cnt[0];
    pulse_start();
    wait_load(0, rst0, "t4_lane0_seen");
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("t4_reset");
    @(negedge clk) rst_n = 1'b1;
    set_masks(32'h01F0_00F8, 32'hFE00_0000, 32'h0000_3000, 32'h0000_03F0);
    pulse_start();
    wait_done("t4_done");
    #1;
    check("t4_taps", 64'(o_tap_data), 64'(taps(5, 28, 16, 6)));
    check("t4_fail", 64'(o_lane_fail), 64'h04);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
